// File: rtl/fifo_rd_packer_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO read-side packer: the default FIFO word
// width, the default number of FIFO words packed per output word, the packer
// FSM state type and a helper that sizes the lane-count field.
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int DATA_WIDTH   = 8;
   localparam int PACK_DEFAULT = 4;

   // FILL  : popping and accumulating FIFO words
   // FULL  : accumulator full, output register still occupied
   // FLUSH : partial word waiting to be emitted
   typedef enum logic [1:0] {
      FILL  = 2'd0,
      FULL  = 2'd1,
      FLUSH = 2'd2
   } packer_state_t;

   // Width of a field able to hold 0..pack.
   function automatic int count_width(input int pack);
      return $clog2(pack + 1);
   endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer_if
// Bundles the FIFO read port, the flush request and the packed output stream.
//   fifo_empty  FIFO empty flag               (FIFO   -> packer)
//   fifo_pop    pop request, one word/cycle   (packer -> FIFO)
//   fifo_data   read data, valid after a pop  (FIFO   -> packer)
//   flush       emit a partially filled word  (env    -> packer)
//   m_data      packed word, lane 0 in LSBs   (packer -> consumer)
//   m_count     valid lanes in m_data         (packer -> consumer)
//   m_valid     m_data/m_count valid          (packer -> consumer)
//   m_ready     consumer accept               (consumer -> packer)
// Modport master is the packer side, slave the environment side.
// -----------------------------------------------------------------------------
interface fifo_rd_packer_if #(
   parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
   parameter int PACK       = fifo_pkg::PACK_DEFAULT
);
   import fifo_pkg::*;

   localparam int CW = count_width(PACK);

   logic                       fifo_empty;
   logic                       fifo_pop;
   logic [DATA_WIDTH-1:0]      fifo_data;
   logic                       flush;
   logic [DATA_WIDTH*PACK-1:0] m_data;
   logic [CW-1:0]              m_count;
   logic                       m_valid;
   logic                       m_ready;

   modport master (
      input  fifo_empty, fifo_data, flush, m_ready,
      output fifo_pop, m_data, m_count, m_valid
   );

   modport slave (
      output fifo_empty, fifo_data, flush, m_ready,
      input  fifo_pop, m_data, m_count, m_valid
   );

endinterface

// File: rtl/fifo_rd_packer_out_reg.sv
// -----------------------------------------------------------------------------
// packer_out_reg
// Output holding register with valid/ready handshake. A loaded word stays
// stable until accepted; the register counts as free in a cycle where it is
// empty or is being accepted, so words can follow back to back.
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_load          take i_data/i_count this edge (only when o_free)
//   i_data          packed word
//   i_count         valid lanes of i_data
//   i_ready         consumer accept
//   o_data/o_count  held word and lane count
//   o_valid         held word valid
//   o_free          register can take a new word this edge
// -----------------------------------------------------------------------------
module packer_out_reg #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 3
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_data,
   input  logic [CNT_W-1:0]  i_count,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data,
   output logic [CNT_W-1:0]  o_count,
   output logic              o_valid,
   output logic              o_free
);

   logic [DATA_W-1:0] r_data;
   logic [CNT_W-1:0]  r_count;
   logic              r_valid;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         // NOTE: the data register is reset too, because m_data must read zero
         // during reset; plain data paths without that need are left unreset.
         r_data  <= '0;
         r_count <= '0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_data  <= i_data;
         r_count <= i_count;
         r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_data  = r_data;
   assign o_count = r_count;
   assign o_valid = r_valid;
   assign o_free  = !r_valid || i_ready;

endmodule

// File: rtl/fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer
// Pops FIFO_WIDTH words from a FIFO read port and packs PACK of them (lane 0 =
// first word) into one output word, or fewer on a flush. PACK range is 2..8.
//   rd_clk  sole clock
//   rd_rst  asynchronous active-low reset, release synchronised internally
//   bus     fifo_rd_packer_if.master (FIFO read port, flush, packed output)
// -----------------------------------------------------------------------------
module fifo_rd_packer #(
   parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
   parameter int PACK       = fifo_pkg::PACK_DEFAULT
) (
   input  logic             rd_clk,
   input  logic             rd_rst,
   fifo_rd_packer_if.master bus
);
   import fifo_pkg::*;

   localparam int            OW     = DATA_WIDTH * PACK;
   localparam int            CW     = count_width(PACK);
   localparam logic [CW-1:0] PACK_C = CW'(PACK);
   localparam logic [CW-1:0] ONE_C  = CW'(1);

   // Reset asserts immediately and releases two rd_clk edges later.
   logic [1:0] r_rst_sync;
   logic       w_rst_n;

   always_ff @(posedge rd_clk or negedge rd_rst) begin
      if (!rd_rst) r_rst_sync <= 2'b00;
      else         r_rst_sync <= {r_rst_sync[0], 1'b1};
   end

   assign w_rst_n = r_rst_sync[1];

   // State FLUSH doubles as the flush-pending flag, so a repeated flush
   // cannot be queued twice.
   packer_state_t r_state;
   logic [CW-1:0] r_cnt;       // captured words in the accumulator
   logic          r_inflight;  // a pop was issued last cycle; data arrives now
   logic [OW-1:0] r_acc;

   logic [CW-1:0] w_cnt_cap;   // counter including this cycle's capture
   logic [OW-1:0] w_acc_cap;   // accumulator including this cycle's capture
   logic          w_full_cap;
   logic          w_out_free;
   logic          w_load;
   logic          w_pop;

   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_acc_cap = r_acc;
      w_cnt_cap = r_cnt;
      if (r_inflight && (r_cnt != PACK_C)) begin
         for (int i = 0; i < PACK; i++) begin
            if (r_cnt == CW'(i)) w_acc_cap[i*DATA_WIDTH +: DATA_WIDTH] = bus.fifo_data;
         end
         w_cnt_cap = r_cnt + ONE_C;
      end
   end

   assign w_full_cap = (w_cnt_cap == PACK_C);

   // FILL emits when the capture completes a word; FULL and FLUSH emit as
   // soon as the output register frees up.
   assign w_load = w_out_free && ((r_state != FILL) || w_full_cap);

   // A pop is allowed while the post-capture occupancy leaves room; a word
   // that drains this edge leaves room, which keeps pops continuous.
   assign w_pop = w_rst_n && !bus.fifo_empty && !bus.flush &&
                  (r_state == FILL) && (!w_full_cap || w_out_free);

   assign bus.fifo_pop = w_pop;

   always_ff @(posedge rd_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state    <= FILL;
         r_cnt      <= '0;
         r_inflight <= 1'b0;
         r_acc      <= '0;
      end else begin
         r_inflight <= w_pop;
         // Clearing on emit keeps unused lanes of a later partial word zero.
         if (w_load) begin
            r_acc <= '0;
            r_cnt <= '0;
         end else begin
            r_acc <= w_acc_cap;
            r_cnt <= w_cnt_cap;
         end
         case (r_state)
            FILL: begin
               if (w_full_cap && !w_out_free)
                  r_state <= FULL;
               else if (bus.flush && !w_full_cap && (w_cnt_cap != '0))
                  r_state <= FLUSH;
            end
            FULL, FLUSH: begin
               if (w_out_free) r_state <= FILL;
            end
            default: r_state <= FILL;
         endcase
      end
   end

   packer_out_reg #(
      .DATA_W (OW),
      .CNT_W  (CW)
   ) u_out_reg (
      .i_clk   (rd_clk),
      .i_rst_n (w_rst_n),
      .i_load  (w_load),
      .i_data  (w_acc_cap),
      .i_count (w_cnt_cap),
      .i_ready (bus.m_ready),
      .o_data  (bus.m_data),
      .o_count (bus.m_count),
      .o_valid (bus.m_valid),
      .o_free  (w_out_free)
   );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_packer
// Directed and randomised bench for fifo_rd_packer (DATA_WIDTH=8, PACK=4).
// The FIFO is a queue in the bench; the reference model is the list of pushed
// words in order, and every accepted output word must equal the next
// min(PACK, remaining) words packed lane 0 first with zero upper lanes.
// -----------------------------------------------------------------------------
module tb_fifo_rd_packer;

   localparam int DW = 8;
   localparam int PK = 4;
   localparam int OW = DW * PK;

   logic clk = 1'b0;
   logic rd_rst;

   always #5 clk = ~clk;

   fifo_rd_packer_if #(.DATA_WIDTH(DW), .PACK(PK)) bus ();

   fifo_rd_packer #(.DATA_WIDTH(DW), .PACK(PK)) dut (
      .rd_clk (clk),
      .rd_rst (rd_rst),
      .bus    (bus)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [DW-1:0] q[$];      // words still in the FIFO
   logic [DW-1:0] mdl[$];    // words pushed and not yet seen at the output
   logic [DW-1:0] hold_word;
   logic        pend = 1'b0;
   int          gap_pct = 0;
   bit          rnd_ready = 1'b0;
   logic        ready_val = 1'b1;
   logic        flush_nxt = 1'b0;
   int          cyc = 0;
   int          first_pop = -1;
   int          first_valid = -1;
   int          n_valid_cyc = 0;
   int          n_out = 0;
   int          base;
   int          xfer_cyc[$];
   logic [OW-1:0] last_data;
   logic [2:0]  last_count;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [DW-1:0] w);
      q.push_back(w);
      mdl.push_back(w);
   endtask

   // One clock cycle: drive inputs on the falling edge, then observe.
   task automatic tick();
      @(negedge clk);
      if (pend) begin
         bus.fifo_data = hold_word;
         pend = 1'b0;
      end
      bus.fifo_empty = (q.size() == 0) || ($urandom_range(99) < gap_pct);
      bus.flush      = flush_nxt;
      flush_nxt      = 1'b0;
      bus.m_ready    = rnd_ready ? ($urandom_range(99) < 70) : ready_val;
      #1;
      cyc++;
      check("pop_while_empty", bus.fifo_pop && bus.fifo_empty, 1'b0);
      if (bus.fifo_pop) begin
         if (first_pop < 0) first_pop = cyc;
         if (q.size() > 0) begin
            hold_word = q.pop_front();
            pend = 1'b1;
         end
      end
      if (bus.m_valid) begin
         if (first_valid < 0) first_valid = cyc;
         n_valid_cyc++;
      end
      if (bus.m_valid && bus.m_ready) begin
         int c;
         logic [OW-1:0] e;
         c = (mdl.size() >= PK) ? PK : mdl.size();
         e = '0;
         for (int i = 0; i < c; i++) e[i*DW +: DW] = mdl[i];
         check("out_count", bus.m_count, c);
         check("out_data", bus.m_data, e);
         for (int i = 0; i < c; i++) void'(mdl.pop_front());
         last_data  = bus.m_data;
         last_count = bus.m_count;
         n_out++;
         xfer_cyc.push_back(cyc);
      end
   endtask

   // Run until the model holds at most target unsent words, bounded.
   task automatic drain(input int target, input int budget, input string tag);
      int n = 0;
      while (mdl.size() > target && n < budget) begin
         tick();
         n++;
      end
      check(tag, mdl.size(), target);
   endtask

   // Run until the FIFO is empty and the last popped word has been captured.
   task automatic settle(input int budget);
      int n = 0;
      while ((q.size() != 0 || pend) && n < budget) begin
         tick();
         n++;
      end
      check("fifo_drained", q.size(), 0);
      repeat (2) tick();
   endtask

   initial begin
      rd_rst         = 1'b0;
      bus.fifo_empty = 1'b1;
      bus.fifo_data  = '0;
      bus.flush      = 1'b0;
      bus.m_ready    = 1'b0;

      // Reset state
      @(posedge clk);
      #1;
      check("rst_pop", bus.fifo_pop, 1'b0);
      check("rst_valid", bus.m_valid, 1'b0);
      check("rst_data", bus.m_data, '0);
      check("rst_count", bus.m_count, '0);
      repeat (2) tick();
      rd_rst = 1'b1;
      repeat (4) tick();

      // Single full word, latency and one-cycle valid
      ready_val = 1'b1;
      first_pop = -1; first_valid = -1; n_valid_cyc = 0; base = n_out;
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      drain(0, 60, "w1_drain");
      repeat (3) tick();
      check("w1_latency", first_valid - first_pop, PK + 1);
      check("w1_valid_cycles", n_valid_cyc, 1);
      check("w1_words", n_out - base, 1);
      check("w1_data", last_data, 32'h44332211);
      check("w1_count", last_count, 3'd4);

      // Sustained throughput: one word every PACK cycles
      xfer_cyc.delete();
      for (int i = 0; i < 12; i++) push(8'(8'h50 + i));
      drain(0, 80, "thru_drain");
      check("thru_words", xfer_cyc.size(), 3);
      check("thru_gap1", xfer_cyc[1] - xfer_cyc[0], PK);
      check("thru_gap2", xfer_cyc[2] - xfer_cyc[1], PK);
      repeat (2) tick();

      // Back-pressure: first word held, accumulator fills, pops stop
      ready_val = 1'b0;
      base = n_out;
      for (int i = 1; i <= 8; i++) push(8'(i));
      for (int t = 0; t < 20; t++) begin
         tick();
         if (t == 9) push(8'h09);
         if (t >= 10) begin
            check("hold_pop", bus.fifo_pop, 1'b0);
            check("hold_valid", bus.m_valid, 1'b1);
            check("hold_data", bus.m_data, 32'h04030201);
            check("hold_count", bus.m_count, 3'd4);
         end
      end
      ready_val = 1'b1;
      tick();
      check("rel_words", n_out - base, 1);
      tick();
      check("next_valid", bus.m_valid, 1'b1);
      check("next_data", bus.m_data, 32'h08070605);
      settle(50);
      flush_nxt = 1'b1;
      tick();
      drain(0, 30, "bp_flush_drain");
      check("bp_flush_data", last_data, 32'h00000009);
      check("bp_flush_count", last_count, 3'd1);

      // Flush of a two-word partial
      base = n_out;
      push(8'hAA); push(8'hBB);
      settle(30);
      flush_nxt = 1'b1;
      tick();
      drain(0, 20, "fl_drain");
      check("fl_words", n_out - base, 1);
      check("fl_data", last_data, 32'h0000BBAA);
      check("fl_count", last_count, 3'd2);

      // Flush with nothing accumulated is ignored
      flush_nxt = 1'b1;
      repeat (6) begin
         tick();
         check("idle_flush_pop", bus.fifo_pop, 1'b0);
         check("idle_flush_valid", bus.m_valid, 1'b0);
      end

      // Asynchronous reset mid-word with a held output
      ready_val = 1'b0;
      for (int i = 0; i < 6; i++) push(8'(8'h61 + i));
      repeat (10) tick();
      check("pre_rst_valid", bus.m_valid, 1'b1);
      #2;
      rd_rst = 1'b0;
      #1;
      check("arst_pop", bus.fifo_pop, 1'b0);
      check("arst_valid", bus.m_valid, 1'b0);
      check("arst_data", bus.m_data, '0);
      check("arst_count", bus.m_count, '0);
      q.delete();
      mdl.delete();
      pend = 1'b0;
      push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
      ready_val = 1'b1;
      repeat (3) begin
         tick();
         check("in_rst_pop", bus.fifo_pop, 1'b0);
      end
      rd_rst = 1'b1;
      tick();
      check("sync_rel_pop", bus.fifo_pop, 1'b0);
      drain(0, 40, "post_rst_drain");
      check("post_rst_data", last_data, 32'hC4C3C2C1);
      check("post_rst_count", last_count, 3'd4);

      // Randomised FIFO gaps and consumer back-pressure
      gap_pct = 40;
      rnd_ready = 1'b1;
      base = n_out;
      for (int i = 0; i < 30; i++) push(8'($urandom));
      drain(30 % PK, 600, "rnd_drain");
      settle(200);
      flush_nxt = 1'b1;
      tick();
      drain(0, 100, "rnd_flush_drain");
      check("rnd_words", n_out - base, 8);
      repeat (4) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
